// File: rtl/mem_bus_arbiter.sv
// Two-port (I-fetch / D-mem) arbiter onto one pulse-based memory bus; one outstanding transaction at a time.
// Optional round-robin conflict resolution when ARB_ROUND_ROBIN_EN is defined; otherwise port D has fixed priority.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_request_enable,
  input  logic                i_mode,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  output logic                i_response_enable,
  output logic [DATA_W-1:0]   i_data,
  input  logic                d_request_enable,
  input  logic                d_mode,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_response_enable,
  output logic [DATA_W-1:0]   d_data,
  output logic                request_enable,
  output logic                mode,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                response_enable,
  input  logic [DATA_W-1:0]   data,
  output logic                busy,
  output logic                owner,
  output logic                proto_err
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              r_state, w_state_next;
  logic                r_i_valid, r_i_mode, r_d_valid, r_d_mode;
  logic [ADDR_W-1:0]   r_i_addr, r_d_addr;
  logic [DATA_W-1:0]   r_i_wdata, r_d_wdata;
  logic [STRB_W-1:0]   r_i_wstrb, r_d_wstrb;
  logic                w_i_own, w_d_own, w_i_drop, w_d_drop, w_i_acc, w_d_acc;
  logic                w_i_cand, w_d_cand, w_grant, w_grant_d, w_done;
  logic                w_g_mode;
  logic [ADDR_W-1:0]   w_g_addr;
  logic [DATA_W-1:0]   w_g_wdata;
  logic [STRB_W-1:0]   w_g_wstrb;
`ifdef ARB_ROUND_ROBIN_EN
  logic                r_last_grant;
`endif

  // A port counts as occupied while it owns the bus, up to the cycle its response arrives.
  assign w_i_own  = (r_state == S_WAIT) && !owner && !response_enable;
  assign w_d_own  = (r_state == S_WAIT) &&  owner && !response_enable;
  assign w_i_drop = i_request_enable && (r_i_valid || w_i_own);
  assign w_d_drop = d_request_enable && (r_d_valid || w_d_own);
  assign w_i_acc  = i_request_enable && !w_i_drop;
  assign w_d_acc  = d_request_enable && !w_d_drop;
  assign w_i_cand = r_i_valid || w_i_acc;
  assign w_d_cand = r_d_valid || w_d_acc;
  assign busy     = (r_state == S_WAIT);

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_d    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_i_cand && w_d_cand) begin
          w_grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          w_grant_d = (r_last_grant == 1'b0);
`else
          w_grant_d = 1'b1;
`endif
        end else if (w_i_cand || w_d_cand) begin
          w_grant   = 1'b1;
          w_grant_d = w_d_cand;
        end
        if (w_grant) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (response_enable) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Granted fields come from the slot if pending, else straight from the incoming pulse.
  always_comb begin
    if (w_grant_d) begin
      w_g_mode  = r_d_valid ? r_d_mode  : d_mode;
      w_g_addr  = r_d_valid ? r_d_addr  : d_addr;
      w_g_wdata = r_d_valid ? r_d_wdata : d_wdata;
      w_g_wstrb = r_d_valid ? r_d_wstrb : d_wstrb;
    end else begin
      w_g_mode  = r_i_valid ? r_i_mode  : i_mode;
      w_g_addr  = r_i_valid ? r_i_addr  : i_addr;
      w_g_wdata = r_i_valid ? r_i_wdata : i_wdata;
      w_g_wstrb = r_i_valid ? r_i_wstrb : i_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_i_valid         <= 1'b0;
      r_i_mode          <= 1'b0;
      r_i_addr          <= '0;
      r_i_wdata         <= '0;
      r_i_wstrb         <= '0;
      r_d_valid         <= 1'b0;
      r_d_mode          <= 1'b0;
      r_d_addr          <= '0;
      r_d_wdata         <= '0;
      r_d_wstrb         <= '0;
      request_enable    <= 1'b0;
      mode              <= 1'b0;
      addr              <= '0;
      wdata             <= '0;
      wstrb             <= '0;
      owner             <= 1'b0;
      i_response_enable <= 1'b0;
      i_data            <= '0;
      d_response_enable <= 1'b0;
      d_data            <= '0;
      proto_err         <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_grant      <= 1'b1;
`endif
    end else begin
      r_state           <= w_state_next;
      request_enable    <= w_grant;
      i_response_enable <= w_done && !owner;
      d_response_enable <= w_done &&  owner;
      i_data            <= (w_done && !owner) ? data : '0;
      d_data            <= (w_done &&  owner) ? data : '0;
      proto_err         <= proto_err || w_i_drop || w_d_drop;
      if (w_grant) begin
        mode  <= w_g_mode;
        addr  <= w_g_addr;
        wdata <= w_g_wdata;
        wstrb <= w_g_wstrb;
        owner <= w_grant_d;
`ifdef ARB_ROUND_ROBIN_EN
        r_last_grant <= w_grant_d;
`endif
      end
      if (w_grant && !w_grant_d) begin
        r_i_valid <= 1'b0;
      end else if (w_i_acc) begin
        r_i_valid <= 1'b1;
        r_i_mode  <= i_mode;
        r_i_addr  <= i_addr;
        r_i_wdata <= i_wdata;
        r_i_wstrb <= i_wstrb;
      end
      if (w_grant && w_grant_d) begin
        r_d_valid <= 1'b0;
      end else if (w_d_acc) begin
        r_d_valid <= 1'b1;
        r_d_mode  <= d_mode;
        r_d_addr  <= d_addr;
        r_d_wdata <= d_wdata;
        r_d_wstrb <= d_wstrb;
      end
    end
  end
endmodule
